// File: rtl/cmp_pkg.sv
// Shared encodings for the sequential magnitude comparator:
// result codes and the scan FSM state type.
package cmp_pkg;
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/chunk_cmp.sv
// Combinational compare of one CHUNK-bit slice. With top_signed set, the MSBs
// are flipped so an unsigned compare gives two's-complement order.
module chunk_cmp
  import cmp_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             top_signed,
  output logic [1:0]       res
);
  logic [CHUNK-1:0] a_m, b_m;

  always_comb begin
    a_m = a;
    b_m = b;
    if (top_signed) begin
      a_m[CHUNK-1] = ~a[CHUNK-1];
      b_m[CHUNK-1] = ~b[CHUNK-1];
    end
    if (a_m < b_m)      res = CMP_LT;
    else if (a_m > b_m) res = CMP_GT;
    else                res = CMP_EQ;
  end
endmodule

// File: rtl/seq_magnitude_comparator.sv
// Valid/ready magnitude comparator: scans operands MSB-first, CHUNK bits per
// clock, stopping at the first differing chunk.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_a,
  input  logic [WIDTH-1:0]                   in_b,
  input  logic                               in_signed,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [1:0]                         out_result,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]   out_chunks
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_magnitude_comparator: illegal WIDTH/CHUNK combination");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] ca, cb;
  logic             top_signed;
  logic [1:0]       cres;

  assign ca         = a_q[idx*CHUNK +: CHUNK];
  assign cb         = b_q[idx*CHUNK +: CHUNK];
  assign top_signed = sgn_q && (idx == IDX_TOP);

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a          (ca),
    .b          (cb),
    .top_signed (top_signed),
    .res        (cres)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SCAN;
      SCAN:    if (cres != CMP_EQ || idx == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand latch, scan index/count and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sgn_q      <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      out_result <= CMP_EQ;
      out_chunks <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= in_a;
          b_q   <= in_b;
          sgn_q <= in_signed;
          idx   <= IDX_TOP;
          cnt   <= '0;
        end
        SCAN: begin
          cnt <= cnt + CW'(1);
          if (cres != CMP_EQ) begin
            out_result <= cres;
            out_chunks <= cnt + CW'(1);
          end else if (idx == '0) begin
            out_result <= CMP_EQ;
            out_chunks <= CW'(NCHUNK);
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed + random bench for seq_magnitude_comparator with CHUNK=8 and
// CHUNK=32 instances, scoreboarded against a behavioural model.
module tb_seq_magnitude_comparator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_signed = 1'b0, out_ready = 1'b0;
  logic        iv8 = 1'b0, iv32 = 1'b0;
  logic        ir8, ir32, ov8, ov32;
  logic [1:0]  r8, r32;
  logic [2:0]  c8;
  logic [0:0]  c32;
  bit          sel = 1'b0;

  logic        rdy, ov;
  logic [31:0] res, chk;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [1:0] r; int n; int lat; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(ov8), .out_ready(out_ready),
    .out_result(r8), .out_chunks(c8)
  );

  seq_magnitude_comparator #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(ov32), .out_ready(out_ready),
    .out_result(r32), .out_chunks(c32)
  );

  always_comb begin
    rdy = sel ? ir32 : ir8;
    ov  = sel ? ov32 : ov8;
    res = sel ? {30'b0, r32} : {30'b0, r8};
    chk = sel ? {31'b0, c32} : {29'b0, c8};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                input int ch, output logic [1:0] r, output int n);
    logic [31:0] d;
    logic [31:0] mask;
    bit lt;
    d    = a ^ b;
    mask = (ch == 32) ? 32'hFFFF_FFFF : ((32'd1 << ch) - 32'd1);
    lt   = s ? ($signed(a) < $signed(b)) : (a < b);
    if (a == b)  r = 2'b00;
    else if (lt) r = 2'b01;
    else         r = 2'b10;
    n = 32 / ch;
    for (int i = 32 / ch - 1; i >= 0; i--) begin
      if (((d >> (i * ch)) & mask) != 0) begin
        n = 32 / ch - i;
        break;
      end
    end
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input bit use32, input int hold);
    exp_t e;
    int   w;
    int   cyc;
    logic [31:0] r_seen, c_seen;
    sel = use32; in_a = a; in_b = b; in_signed = s;
    model(a, b, s, use32 ? 32 : 8, e.r, e.n);
    e.lat = e.n + 1;
    sb.push_back(e);
    if (use32) iv32 = 1'b1; else iv8 = 1'b1;
    w = 0;
    while (!rdy && w < 50) begin @(posedge clk); #1; w++; end
    check("in_ready_before_accept", {31'b0, rdy}, 1);
    @(posedge clk); #1;
    iv8 = 1'b0; iv32 = 1'b0;
    cyc = 1;
    while (!ov && cyc < 60) begin @(posedge clk); #1; cyc++; end
    e = sb.pop_front();
    check("out_valid", {31'b0, ov}, 1);
    check("out_result", res, {30'b0, e.r});
    check("out_chunks", chk, e.n);
    check("latency", cyc, e.lat);
    if (hold > 0) begin
      r_seen = res; c_seen = chk;
      in_a = ~a; in_b = a;
      if (use32) iv32 = 1'b1; else iv8 = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("hold_out_valid", {31'b0, ov}, 1);
        check("hold_out_result", res, {30'b0, e.r});
        check("hold_out_chunks", chk, c_seen);
        check("hold_in_ready", {31'b0, rdy}, 0);
      end
      iv8 = 1'b0; iv32 = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", {31'b0, ov}, 0);
    check("idle_in_ready", {31'b0, rdy}, 1);
  endtask

  initial begin
    logic [31:0] a, b;
    bit seen_valid;
    int m;

    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    check("rst_in_ready", {31'b0, rdy}, 1);
    check("rst_out_valid", {31'b0, ov}, 0);
    check("rst_out_result", res, 0);
    check("rst_out_chunks", chk, 0);
    sel = 1'b1;
    check("rst32_in_ready", {31'b0, rdy}, 1);
    check("rst32_out_valid", {31'b0, ov}, 0);
    rst = 1'b0;

    run_txn(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 0);
    run_txn(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0);
    run_txn(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 0);
    run_txn(32'h0000_00FF, 32'h0000_00FE, 1'b0, 1'b0, 0);
    run_txn(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 5);
    run_txn(32'h0000_0055, 32'h0000_0054, 1'b1, 1'b0, 0);

    // Abort in the second scan cycle; no result may follow.
    sel = 1'b0; in_a = 32'h1234_5678; in_b = 32'h1234_5678; in_signed = 1'b0;
    iv8 = 1'b1;
    check("abort_in_ready", {31'b0, rdy}, 1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready_after", {31'b0, rdy}, 1);
    check("abort_out_valid", {31'b0, ov}, 0);
    check("abort_out_result", res, 0);
    check("abort_out_chunks", chk, 0);
    seen_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (ov) seen_valid = 1'b1; end
    check("abort_no_result", {31'b0, seen_valid}, 0);

    run_txn(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 0);
    run_txn(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 0);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      run_txn(a, b, 1'($urandom_range(0, 1)), 1'b1, 0);
    end

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      m = $urandom_range(0, 3);
      b = a;
      if (m == 1) b = $urandom;
      else if (m >= 2) b = a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
      run_txn(a, b, 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
